burst_pulse_gen: RTL and testbench

BURST_PULSE_GEN -- requirements
Module: burst_pulse_gen

---
 rtl/burst_pulse_pkg.sv | 25 ++
 rtl/burst_edge_det.sv | 29 ++
 rtl/burst_pulse_gen.sv | 200 ++++++++++++++++++++
 tb/tb_burst_pulse_gen.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/burst_pulse_pkg.sv
// Purpose: shared state encoding, default widths and minimum half-period for the burst pulse generator.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package burst_pulse_pkg;

    // Default counter widths used by the top-level parameters.
    localparam int DEF_CNT_W = 16;
    localparam int DEF_NUM_W = 8;

    // Shortest half-period the output stage may produce. Smaller settings are raised to this value.
    localparam int MIN_HALF  = 2;

    // Burst sequencer states. DAMP exists only in builds that include the damping phase.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DELAY = 3'd1,
        ST_POS   = 3'd2,
        ST_NEG   = 3'd3,
`ifdef BURST_PULSE_DAMP_EN
        ST_DAMP  = 3'd4,
`endif
        ST_DONE  = 3'd5
    } state_t;

endpackage

// File: rtl/burst_edge_det.sv
// Purpose: registered rising-edge detector for the burst sync input.
// Latency: rise is high in the cycle after the edge that first samples sig=1 following a 0 sample.
// Backpressure: none; one pulse per 0->1 transition, a level already high at reset release never fires.
module burst_edge_det (
    input  logic clk_100,
    input  logic reset_n,
    input  logic sig,
    output logic rise
);

    // Previous sample of sig, and a flag that is clear until the first post-reset sample exists.
    logic sig_q;
    logic armed;

    // Sample sig each cycle; suppress detection on the first sample after reset so a
    // level held high through reset release is not mistaken for a fresh edge.
    always_ff @(posedge clk_100 or negedge reset_n) begin
        if (!reset_n) begin
            sig_q <= 1'b0;
            armed <= 1'b0;
            rise  <= 1'b0;
        end else begin
            sig_q <= sig;
            armed <= 1'b1;
            rise  <= armed & sig & ~sig_q;
        end
    end

endmodule

// File: rtl/burst_pulse_gen.sv
// Purpose: ultrasound transmit burst sequencer: start delay, N bipolar P/N pairs, optional damping (BURST_PULSE_DAMP_EN).
// Latency: tx_busy one cycle after the detected sync edge, first tx_p D cycles after that, burst_done one cycle after the last drive.
// Backpressure: none; triggers while busy are dropped and flagged by a one-cycle overrun pulse, enable low aborts the burst.
module burst_pulse_gen
    import burst_pulse_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int NUM_W = DEF_NUM_W
) (
    input  logic             clk_100,
    input  logic             reset_n,
    input  logic             burst_syn,
    input  logic             enable,
    input  logic [CNT_W-1:0] cfg_start_delay,
    input  logic [CNT_W-1:0] cfg_half_period,
    input  logic [NUM_W-1:0] cfg_pulse_num,
    output logic             tx_p,
    output logic             tx_n,
    output logic             tx_damp,
    output logic             tx_busy,
    output logic             burst_done,
    output logic             overrun
);

    localparam logic [CNT_W-1:0] MIN_H    = CNT_W'(MIN_HALF);
    localparam logic [CNT_W:0]   CNT_ONE  = {{CNT_W{1'b0}}, 1'b1};
    localparam logic [NUM_W-1:0] PAIR_ONE = {{(NUM_W-1){1'b0}}, 1'b1};

    // Sync edge pulse, one cycle wide.
    logic trig;

    // Sequencer state and counters. The phase counter is one bit wider than the
    // config so it can reach 2*H during damping; it starts at 1 on phase entry and
    // the phase ends when it equals the target, so it never wraps even at the
    // largest delay or pulse count.
    state_t           state;
    logic [CNT_W:0]   cnt;
    logic [NUM_W-1:0] pair_cnt;

    // Configuration captured when a burst is accepted.
    logic [CNT_W-1:0] delay_q;
    logic [CNT_W-1:0] half_q;
    logic [NUM_W-1:0] num_q;

    // Phase-end targets at counter width.
    logic [CNT_W:0]   delay_x;
    logic [CNT_W:0]   half_x;
`ifdef BURST_PULSE_DAMP_EN
    logic [CNT_W:0]   half2_x;
`endif

    burst_edge_det u_edge_det (
        .clk_100 (clk_100),
        .reset_n (reset_n),
        .sig     (burst_syn),
        .rise    (trig)
    );

    assign delay_x = {1'b0, delay_q};
    assign half_x  = {1'b0, half_q};
`ifdef BURST_PULSE_DAMP_EN
    assign half2_x = {half_q, 1'b0};
`else
    // No damping phase in this build: the damping switch is never closed.
    assign tx_damp = 1'b0;
`endif

    // Burst sequencer with registered drive/status outputs.
    always_ff @(posedge clk_100 or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            pair_cnt   <= '0;
            delay_q    <= '0;
            half_q     <= '0;
            num_q      <= '0;
            tx_p       <= 1'b0;
            tx_n       <= 1'b0;
`ifdef BURST_PULSE_DAMP_EN
            tx_damp    <= 1'b0;
`endif
            tx_busy    <= 1'b0;
            burst_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            burst_done <= 1'b0;
            // A trigger landing on an active burst is reported but otherwise ignored.
            overrun    <= trig & tx_busy;

            if ((state != ST_IDLE) && (state != ST_DONE) && !enable) begin
                // Enable withdrawn mid-burst: release every switch at once, no done pulse.
                state    <= ST_IDLE;
                cnt      <= '0;
                pair_cnt <= '0;
                tx_p     <= 1'b0;
                tx_n     <= 1'b0;
`ifdef BURST_PULSE_DAMP_EN
                tx_damp  <= 1'b0;
`endif
                tx_busy  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (trig && enable && (cfg_pulse_num != '0)) begin
                            delay_q  <= cfg_start_delay;
                            half_q   <= (cfg_half_period < MIN_H) ? MIN_H : cfg_half_period;
                            num_q    <= cfg_pulse_num;
                            pair_cnt <= PAIR_ONE;
                            cnt      <= CNT_ONE;
                            tx_busy  <= 1'b1;
                            if (cfg_start_delay == '0) begin
                                state <= ST_POS;
                                tx_p  <= 1'b1;
                            end else begin
                                state <= ST_DELAY;
                            end
                        end
                    end

                    ST_DELAY: begin
                        if (cnt == delay_x) begin
                            state <= ST_POS;
                            cnt   <= CNT_ONE;
                            tx_p  <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end

                    ST_POS: begin
                        if (cnt == half_x) begin
                            state <= ST_NEG;
                            cnt   <= CNT_ONE;
                            tx_p  <= 1'b0;
                            tx_n  <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end

                    ST_NEG: begin
                        if (cnt == half_x) begin
                            cnt  <= CNT_ONE;
                            tx_n <= 1'b0;
                            if (pair_cnt == num_q) begin
`ifdef BURST_PULSE_DAMP_EN
                                state   <= ST_DAMP;
                                tx_damp <= 1'b1;
`else
                                state      <= ST_DONE;
                                tx_busy    <= 1'b0;
                                burst_done <= 1'b1;
`endif
                            end else begin
                                state    <= ST_POS;
                                pair_cnt <= pair_cnt + PAIR_ONE;
                                tx_p     <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end

`ifdef BURST_PULSE_DAMP_EN
                    ST_DAMP: begin
                        if (cnt == half2_x) begin
                            state      <= ST_DONE;
                            cnt        <= '0;
                            tx_damp    <= 1'b0;
                            tx_busy    <= 1'b0;
                            burst_done <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
`endif

                    ST_DONE: begin
                        state    <= ST_IDLE;
                        cnt      <= '0;
                        pair_cnt <= '0;
                    end

                    default: begin
                        state    <= ST_IDLE;
                        cnt      <= '0;
                        pair_cnt <= '0;
                        tx_p     <= 1'b0;
                        tx_n     <= 1'b0;
`ifdef BURST_PULSE_DAMP_EN
                        tx_damp  <= 1'b0;
`endif
                        tx_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_burst_pulse_gen.sv
// Purpose: scoreboard bench for burst_pulse_gen; expected output transitions are queued at stimulus time.
// Latency: every output edge is checked against the cycle number computed from the trigger cycle.
// Backpressure: a forked monitor pops the matching expected transition whenever any output changes.
module tb_burst_pulse_gen;

    localparam int CNT_W = 16;
    localparam int NUM_W = 8;

    localparam int S_P  = 0;
    localparam int S_N  = 1;
    localparam int S_D  = 2;
    localparam int S_B  = 3;
    localparam int S_DN = 4;
    localparam int S_O  = 5;

    typedef struct {
        int sig;
        int lvl;
        int cyc;
    } ev_t;

    logic             clk_100 = 1'b0;
    logic             reset_n = 1'b0;
    logic             burst_syn = 1'b0;
    logic             enable = 1'b0;
    logic [CNT_W-1:0] cfg_start_delay = '0;
    logic [CNT_W-1:0] cfg_half_period = '0;
    logic [NUM_W-1:0] cfg_pulse_num = '0;
    logic             tx_p, tx_n, tx_damp, tx_busy, burst_done, overrun;

    int        cyc = 0;
    int        tests = 0;
    int        fails = 0;
    int        overlap = 0;
    ev_t       exp_q[$];
    string     sname [6] = '{"tx_p", "tx_n", "tx_damp", "tx_busy", "burst_done", "overrun"};
    bit [5:0]  mon_prev = '0;
    bit [5:0]  mon_cur;
    int        mon_found;
    int        t0, t1, cut;

    burst_pulse_gen #(.CNT_W(CNT_W), .NUM_W(NUM_W)) dut (
        .clk_100         (clk_100),
        .reset_n         (reset_n),
        .burst_syn       (burst_syn),
        .enable          (enable),
        .cfg_start_delay (cfg_start_delay),
        .cfg_half_period (cfg_half_period),
        .cfg_pulse_num   (cfg_pulse_num),
        .tx_p            (tx_p),
        .tx_n            (tx_n),
        .tx_damp         (tx_damp),
        .tx_busy         (tx_busy),
        .burst_done      (burst_done),
        .overrun         (overrun)
    );

    always #5 clk_100 = ~clk_100;

    always @(posedge clk_100) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int s, input int l, input int c);
        exp_q.push_back('{s, l, c});
    endtask

    // High interval [r, f); an abort at cycle cut truncates it there.
    task automatic push_pulse(input int s, input int r, input int f, input int cut_c);
        if (cut_c == 0 || f <= cut_c) begin
            push(s, 1, r);
            push(s, 0, f);
        end else if (r < cut_c) begin
            push(s, 1, r);
            push(s, 0, cut_c);
        end
    endtask

    // Expected transitions of a burst triggered at cycle t; returns the cycle after done.
    task automatic expect_burst(input int t, input int d, input int h, input int n,
                                input int cut_c, output int fin);
        int he, p0, e;
        he = (h < 2) ? 2 : h;
        p0 = t + 1 + d;
        for (int k = 0; k < n; k++) begin
            push_pulse(S_P, p0 + 2*he*k,      p0 + 2*he*k + he, cut_c);
            push_pulse(S_N, p0 + 2*he*k + he, p0 + 2*he*(k+1),  cut_c);
        end
        e = p0 + 2*he*n;
`ifdef BURST_PULSE_DAMP_EN
        push_pulse(S_D, e, e + 2*he, cut_c);
        e = e + 2*he;
`endif
        push_pulse(S_B, t + 1, e, cut_c);
        if (cut_c == 0) push_pulse(S_DN, e, e + 1, 0);
        fin = e + 1;
    endtask

    task automatic set_cfg(input int d, input int h, input int n);
        cfg_start_delay = CNT_W'(d);
        cfg_half_period = CNT_W'(h);
        cfg_pulse_num   = NUM_W'(n);
    endtask

    // Raise burst_syn so the next rising clock edge (cycle t) samples it, then drop it.
    task automatic trigger(output int t);
        @(negedge clk_100);
        burst_syn = 1'b1;
        t = cyc + 1;
        @(negedge clk_100);
        burst_syn = 1'b0;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk_100);
    endtask

    task automatic run_burst(input int d, input int h, input int n);
        int t, fin;
        set_cfg(d, h, n);
        trigger(t);
        expect_burst(t, d, h, n, 0, fin);
        wait_until(fin + 3);
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk_100);
                mon_cur = {overrun, burst_done, tx_busy, tx_damp, tx_n, tx_p};
                if (int'(tx_p) + int'(tx_n) + int'(tx_damp) > 1) overlap++;
                for (int s = 0; s < 6; s++) begin
                    if (mon_cur[s] != mon_prev[s]) begin
                        mon_found = -1;
                        for (int i = 0; i < exp_q.size(); i++) begin
                            if (exp_q[i].sig == s) begin
                                mon_found = i;
                                break;
                            end
                        end
                        if (mon_found < 0) begin
                            check({"unexpected edge on ", sname[s]}, cyc, -1);
                        end else begin
                            check({sname[s], " level"}, int'(mon_cur[s]), exp_q[mon_found].lvl);
                            check({sname[s], " edge cycle"}, cyc, exp_q[mon_found].cyc);
                            exp_q.delete(mon_found);
                        end
                    end
                end
                mon_prev = mon_cur;
            end
        join_none

        // Reset state.
        repeat (3) @(negedge clk_100);
        check("reset tx_p", int'(tx_p), 0);
        check("reset tx_n", int'(tx_n), 0);
        check("reset tx_damp", int'(tx_damp), 0);
        check("reset tx_busy", int'(tx_busy), 0);
        check("reset burst_done", int'(burst_done), 0);
        check("reset overrun", int'(overrun), 0);
        reset_n = 1'b1;
        enable  = 1'b1;
        repeat (3) @(negedge clk_100);

        // Reference burst: D=10, H=50, N=3 -> tx_p T+11..T+60, burst_done T+311.
        run_burst(10, 50, 3);
        // Zero delay and sub-minimum half-periods.
        run_burst(0, 0, 2);
        run_burst(3, 1, 1);
        // Zero pulse count and disabled transmitter: triggers dropped.
        set_cfg(4, 4, 0);
        trigger(t0);
        wait_until(t0 + 20);
        enable = 1'b0;
        set_cfg(4, 4, 2);
        trigger(t0);
        wait_until(t0 + 30);
        enable = 1'b1;

        // Overrun plus mid-burst config change: first burst must stay unchanged.
        set_cfg(2, 10, 2);
        trigger(t0);
        expect_burst(t0, 2, 10, 2, 0, t1);
        wait_until(t0 + 3);
        set_cfg(0, 3, 5);
        trigger(cut);
        push_pulse(S_O, cut + 1, cut + 2, 0);
        wait_until(t1 + 3);

        // Enable dropped during the second tx_n (D=1, H=6: second tx_n is T+20..T+25).
        set_cfg(1, 6, 3);
        trigger(t0);
        expect_burst(t0, 1, 6, 3, t0 + 22, t1);
        wait_until(t0 + 21);
        enable = 1'b0;
        @(negedge clk_100);
        enable = 1'b1;
        wait_until(t0 + 40);
        run_burst(1, 6, 3);

        // Largest pulse count.
        run_burst(0, 2, 255);

        // Damping burst (damping phase expected only in builds that include it).
        run_burst(0, 25, 1);

        // Asynchronous reset during tx_p, then sync held high through reset release.
        set_cfg(0, 20, 2);
        trigger(t0);
        expect_burst(t0, 0, 20, 2, t0 + 5, t1);
        wait_until(t0 + 4);
        @(posedge clk_100);
        #2 reset_n = 1'b0;
        #1;
        check("async reset tx_p", int'(tx_p), 0);
        check("async reset tx_busy", int'(tx_busy), 0);
        burst_syn = 1'b1;
        repeat (2) @(negedge clk_100);
        reset_n = 1'b1;
        repeat (30) @(negedge clk_100);
        burst_syn = 1'b0;
        repeat (5) @(negedge clk_100);

        // Recovery after reset.
        run_burst(2, 3, 2);

        check("pending expected edges", exp_q.size(), 0);
        check("tx drive overlap cycles", overlap, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
